// File: rtl/traffic_light_pkg.sv
// Shared types and defaults for the traffic light controller: state encoding,
// default dwell lengths and the dwell-counter width helper.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    localparam int RED_CYCLES_DEF    = 32;
    localparam int GREEN_CYCLES_DEF  = 20;
    localparam int YELLOW_CYCLES_DEF = 7;

    // Counter holds 0..max-1, so ceil(log2(max)) bits suffice; never below 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/traffic_light_timer.sv
// Enable-gated dwell counter: counts 0..last_i, flags done_o on the terminal
// enabled edge and self-clears on that edge or on a synchronous clear.
module traffic_light_timer
    import traffic_light_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable_i,
    input  logic          clear_i,
    input  logic [CW-1:0] last_i,
    output logic [CW-1:0] count_o,
    output logic          done_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign done_o  = enable_i && (count_q == last_i);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i || done_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/traffic_light_module.sv
// Traffic light controller: RED -> GREEN -> YELLOW with per-state dwell and freeze on enable=0.
// Define TRAFFIC_LIGHT_STATUS_EN to expose state_o / dwell_o status outputs.
module traffic_light_module
    import traffic_light_pkg::*;
#(
    parameter int RED_CYCLES    = RED_CYCLES_DEF,
    parameter int GREEN_CYCLES  = GREEN_CYCLES_DEF,
    parameter int YELLOW_CYCLES = YELLOW_CYCLES_DEF,
    localparam int CW = cnt_width(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          red,
    output logic          yellow,
    output logic          green
`ifdef TRAFFIC_LIGHT_STATUS_EN
    ,
    output logic [1:0]    state_o,
    output logic [CW-1:0] dwell_o
`endif
);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] last;
    logic [CW-1:0] count;
    logic          done;
    logic          illegal;

    always_comb begin
        last    = '0;
        illegal = 1'b0;
        case (state_q)
            S_RED:    last = CW'(RED_CYCLES - 1);
            S_GREEN:  last = CW'(GREEN_CYCLES - 1);
            S_YELLOW: last = CW'(YELLOW_CYCLES - 1);
            default:  illegal = 1'b1;
        endcase
    end

    traffic_light_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .enable_i (enable),
        .clear_i  (illegal),
        .last_i   (last),
        .count_o  (count),
        .done_o   (done)
    );

    // An unused encoding returns to RED regardless of enable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RED:    if (done) state_d = S_GREEN;
            S_GREEN:  if (done) state_d = S_YELLOW;
            S_YELLOW: if (done) state_d = S_RED;
            default:  state_d = S_RED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RED;
        end else begin
            state_q <= state_d;
        end
    end

    assign green  = (state_q == S_GREEN);
    assign yellow = (state_q == S_YELLOW);
    assign red    = !(green || yellow);

`ifdef TRAFFIC_LIGHT_STATUS_EN
    assign state_o = state_q;
    assign dwell_o = count;
`endif

endmodule

// File: tb/tb_traffic_light_module.sv
// Scoreboard bench: default-parameter DUT and a 1/1/1 DUT driven side by side.
module tb_traffic_light_module;

    logic clk;
    logic reset;
    logic enable;
    logic red0, yellow0, green0;
    logic red1, yellow1, green1;
`ifdef TRAFFIC_LIGHT_STATUS_EN
    logic [1:0] state0;
    logic [4:0] dwell0;
    logic [1:0] state1;
    logic [0:0] dwell1;
`endif

    traffic_light_module dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .red    (red0),
        .yellow (yellow0),
        .green  (green0)
`ifdef TRAFFIC_LIGHT_STATUS_EN
        ,
        .state_o(state0),
        .dwell_o(dwell0)
`endif
    );

    traffic_light_module #(
        .RED_CYCLES   (1),
        .GREEN_CYCLES (1),
        .YELLOW_CYCLES(1)
    ) dut_min (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .red    (red1),
        .yellow (yellow1),
        .green  (green1)
`ifdef TRAFFIC_LIGHT_STATUS_EN
        ,
        .state_o(state1),
        .dwell_o(dwell1)
`endif
    );

    typedef struct {
        int l0;
        int l1;
        int st0;
        int st1;
        int dw0;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n     = 0;   // enabled edges since last reset release

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t, n=%0d)", nm, act, exp, $time, n);
        end
    endtask

    // Default timing: RED edges 0..31, GREEN 32..51, YELLOW 52..58 of each 59-edge pass.
    function automatic int st_main(input int k);
        int p;
        p = k % 59;
        if (p < 32) return 0;
        if (p < 52) return 1;
        return 2;
    endfunction

    function automatic int dw_main(input int k);
        int p;
        p = k % 59;
        if (p < 32) return p;
        if (p < 52) return p - 32;
        return p - 52;
    endfunction

    // Lamp vector {red,yellow,green} for a state code.
    function automatic int lamp_of(input int st);
        if (st == 0) return 4;
        if (st == 1) return 1;
        return 2;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.st0 = st_main(n);
        e.dw0 = dw_main(n);
        e.l0  = lamp_of(e.st0);
        e.st1 = n % 3;
        e.l1  = lamp_of(e.st1);
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!reset && enable) n++;
        push_exp();
    endtask

    // Monitor: one expectation per falling edge, once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("lamps", int'({red0, yellow0, green0}), e.l0);
                chk("onehot", $countones({red0, yellow0, green0}), 1);
                chk("lamps_min", int'({red1, yellow1, green1}), e.l1);
                chk("onehot_min", $countones({red1, yellow1, green1}), 1);
`ifdef TRAFFIC_LIGHT_STATUS_EN
                chk("state_o", int'(state0), e.st0);
                chk("dwell_o", int'(dwell0), e.dw0);
                chk("state_o_min", int'(state1), e.st1);
                chk("dwell_o_min", int'(dwell1), 0);
`endif
            end
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        #1;
        chk("reset_lamps", int'({red0, yellow0, green0}), 4);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b0;

        // Three full passes.
        for (int i = 0; i < 177; i++) step();

        // Freeze at start of RED, then mid-RED.
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) step();
        enable = 1'b1;
        for (int i = 0; i < 200 && (n % 59) != 40; i++) step();
        chk("reached_green_40", n % 59, 40);

        // Asynchronous reset pulse mid-GREEN, between clock edges.
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_red", int'({red0, yellow0, green0}), 4);
        n = 0;
        push_exp();
        @(negedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) step();

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
